// File: rtl/pwm_audio_out.sv
// pwm_audio_out: turns a signed PCM sample into a fixed-rate PWM stream on a complementary pair.
//
// The period is 2**PWM_BITS clocks. The duty cycle is the top PWM_BITS bits of the sample in offset
// binary. It is latched once per period at the counter wrap, so changing the sample mid-period never
// produces a glitch.
//
// Ports
//   clk_i     : system clock, rising edge
//   rst_ni    : asynchronous active-low reset; release is synchronised internally
//   sample_i  : signed (two's complement) audio sample, may change any cycle
//   pwm_p_o   : PWM output, high for duty cycles of every period
//   pwm_n_o   : complement of pwm_p_o outside reset; both low while in reset
module pwm_audio_out #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic                       pwm_p_o,
  output logic                       pwm_n_o
);

  if (PWM_BITS > SAMPLE_W || PWM_BITS < 2) begin : gen_param_check
    $error("pwm_audio_out: PWM_BITS must be in 2..SAMPLE_W");
  end

  localparam logic [PWM_BITS-1:0] CntMax  = '1;
  localparam logic [PWM_BITS-1:0] CntOne  = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] DutyMid = {1'b1, {(PWM_BITS-1){1'b0}}};

  // Reset assert is asynchronous; release passes through two flops so that all state leaves reset
  // on the same, clean edge.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  // Offset binary is the sample with its MSB inverted; the duty keeps only the top PWM_BITS bits.
  logic [PWM_BITS-1:0] duty_next;
  assign duty_next = {~sample_i[SAMPLE_W-1], sample_i[SAMPLE_W-2 -: (PWM_BITS-1)]};

  if (SAMPLE_W > PWM_BITS) begin : gen_unused_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^sample_i[SAMPLE_W-PWM_BITS-1:0];
  end

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_p_q, pwm_p_d;
  logic                pwm_n_q, pwm_n_d;
  logic                active;

  always_comb begin
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    pwm_p_d = pwm_p_q;
    pwm_n_d = pwm_n_q;
    active  = (cnt_q < duty_q);
    if (run) begin
      cnt_d   = cnt_q + CntOne;
      // New duty only at the period boundary (cnt wrapping MAX -> 0).
      if (cnt_q == CntMax) begin
        duty_d = duty_next;
      end
      pwm_p_d = active;
      pwm_n_d = ~active;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      duty_q  <= DutyMid;
      pwm_p_q <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_p_q <= pwm_p_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_p_o = pwm_p_q;
  assign pwm_n_o = pwm_n_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
module tb_pwm_audio_out;

  logic               clk;
  logic               rst_ni;
  logic signed [15:0] sample;
  logic               pwm_p;
  logic               pwm_n;

  int checks   = 0;
  int failures = 0;

  bit ramp_on = 1'b0;
  int ramp_k  = 0;

  pwm_audio_out #(
    .SAMPLE_W(16),
    .PWM_BITS(8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .sample_i(sample),
    .pwm_p_o (pwm_p),
    .pwm_n_o (pwm_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples the outputs over one 256-cycle period. In ramp mode the sample follows the ramp; otherwise
  // the sample switches to chg_val before the chg_at'th cycle (chg_at < 0: no change).
  task automatic run_period(input int chg_at, input logic [15:0] chg_val,
                            output int highs, output int comp_err);
    highs    = 0;
    comp_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (ramp_on) begin
        if (ramp_k % 20 == 0) sample = 16'h8000 + 16'((ramp_k / 20) * 256);
        ramp_k++;
      end else if (i == chg_at) begin
        sample = chg_val;
      end
      @(negedge clk);
      if (pwm_p === 1'b1) highs++;
      if (pwm_n !== ~pwm_p) comp_err++;
    end
  endtask

  function automatic int duty_of(input logic [15:0] s);
    logic [15:0] off;
    off = s ^ 16'h8000;
    return int'(off[15:8]);
  endfunction

  initial begin
    int h, c, errs, exp_h;
    rst_ni = 1'b0;
    sample = 16'sh8000;

    // Reset: both outputs low for the whole hold.
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (pwm_p !== 1'b0 || pwm_n !== 1'b0) errs++;
    end
    check_eq("rst_outputs_low", errs, 0);
    check_eq("rst_p", int'(pwm_p), 0);
    check_eq("rst_n", int'(pwm_n), 0);

    // Release at a negedge; two sync flops, then the third edge counts cnt=0.
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);

    run_period(-1, 16'h0000, h, c);
    check_eq("p1_midscale_hi", h, 128);
    check_eq("p1_comp", c, 0);
    run_period(0, 16'h0000, h, c);
    check_eq("p2_fullneg_hi", h, 0);
    check_eq("p2_comp", c, 0);
    run_period(-1, 16'h0000, h, c);
    check_eq("p3_mid_hi", h, 128);
    check_eq("p3_comp", c, 0);
    run_period(0, 16'h7FFF, h, c);
    check_eq("p4_mid_hi", h, 128);
    run_period(0, 16'h0000, h, c);
    check_eq("p5_fullpos_hi", h, 255);
    check_eq("p5_comp", c, 0);
    run_period(50, 16'h4000, h, c);
    check_eq("p6_midchange_hi", h, 128);
    run_period(-1, 16'h0000, h, c);
    check_eq("p7_after_change_hi", h, 192);
    check_eq("p7_comp", c, 0);

    // Ramp: each period's high count is the duty of the sample present at the preceding wrap.
    exp_h   = 192;
    ramp_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      run_period(-1, 16'h0000, h, c);
      check_eq($sformatf("ramp_hi_%0d", p), h, exp_h);
      check_eq($sformatf("ramp_comp_%0d", p), c, 0);
      exp_h = duty_of(sample);
    end

    // Reset in the middle of a period of duty 255: outputs drop at once, not at the next edge.
    for (int i = 0; i < 100; i++) begin
      if (ramp_k % 20 == 0) sample = 16'h8000 + 16'((ramp_k / 20) * 256);
      ramp_k++;
      @(negedge clk);
    end
    check_eq("pre_rst_p", int'(pwm_p), 1);
    check_eq("pre_rst_n", int'(pwm_n), 0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("async_rst_p", int'(pwm_p), 0);
    check_eq("async_rst_n", int'(pwm_n), 0);
    repeat (5) @(negedge clk);
    check_eq("held_rst_p", int'(pwm_p), 0);
    check_eq("held_rst_n", int'(pwm_n), 0);

    ramp_on = 1'b0;
    sample  = 16'sh7FFF;
    rst_ni  = 1'b1;
    repeat (3) @(posedge clk);
    run_period(-1, 16'h0000, h, c);
    check_eq("rerun_midscale_hi", h, 128);
    check_eq("rerun_comp", c, 0);
    run_period(-1, 16'h0000, h, c);
    check_eq("rerun_fullpos_hi", h, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
